// File: rtl/note_player.sv
// Buffered square-wave note player: a small {period, dur} FIFO drained back-to-back
// into a complementary piezo drive, with a done pulse when the queue runs dry.
module note_player #(
    parameter int FAST_SIM = 0,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [14:0] period,
    input  logic [23:0] dur,
    input  logic        clr,
    output logic        full,
    output logic        playing,
    output logic        done,
    output logic        piezo,
    output logic        piezo_n
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [23:0]   STEP     = (FAST_SIM != 0) ? 24'd16 : 24'd1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    PLAY     = 1'b1;

    logic [38:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [14:0]   per_q, per_d, tone_q, tone_d;
    logic [23:0]   dur_q, dur_d;
    logic          full_q, playing_q, done_q, piezo_q, piezo_n_q;
    logic          push, pop, done_d, sound_d, piezo_d;
    logic [38:0]   head;
    logic [15:0]   half_d;

    assign head = mem_q[rd_ptr_q];
    // Full is judged on the pre-pop count: a push while full is dropped even if a pop frees a slot.
    assign push = wr_en && (count_q != CNT_FULL) && !clr;

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        dur_d   = dur_q;
        tone_d  = tone_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        if (clr) begin
            state_d = IDLE;
            per_d   = '0;
            dur_d   = '0;
            tone_d  = '0;
        end else if (state_q == IDLE) begin
            pop = (count_q != '0);
        end else if (dur_q <= STEP) begin
            if (count_q != '0) begin
                pop = 1'b1;
            end else begin
                state_d = IDLE;
                per_d   = '0;
                dur_d   = '0;
                tone_d  = '0;
                done_d  = 1'b1;
            end
        end else begin
            dur_d  = dur_q - STEP;
            tone_d = (per_q == '0 || tone_q == per_q - 15'd1) ? '0 : tone_q + 15'd1;
        end
        if (pop) begin
            state_d = PLAY;
            per_d   = head[38:24];
            dur_d   = head[23:0];
            tone_d  = '0;
        end
    end

    assign wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
    assign rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    assign count_d  = clr ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);

    assign sound_d = (state_d == PLAY) && (per_d != '0);
    assign half_d  = ({1'b0, per_d} + 16'd1) >> 1;
    assign piezo_d = sound_d && ({1'b0, tone_d} < half_d);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {period, dur};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            per_q     <= '0;
            dur_q     <= '0;
            tone_q    <= '0;
            full_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            per_q     <= per_d;
            dur_q     <= dur_d;
            tone_q    <= tone_d;
            full_q    <= (count_d == CNT_FULL);
            playing_q <= (state_d == PLAY);
            done_q    <= done_d;
            piezo_q   <= piezo_d;
            piezo_n_q <= sound_d && !piezo_d;
        end
    end

    assign full    = full_q;
    assign playing = playing_q;
    assign done    = done_q;
    assign piezo   = piezo_q;
    assign piezo_n = piezo_n_q;
endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: one instance per FAST_SIM setting; expected
// {piezo, piezo_n} per PLAY cycle and done tokens are queued as notes are pushed.
module tb_note_player;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr0 = 1'b0, clr0 = 1'b0, wr1 = 1'b0, clr1 = 1'b0;
    logic [14:0] per0 = '0, per1 = '0;
    logic [23:0] dur0 = '0, dur1 = '0;
    logic        full0, playing0, done0, piezo0, piezo_n0;
    logic        full1, playing1, done1, piezo1, piezo_n1;

    note_player #(.FAST_SIM(0), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr0), .period(per0), .dur(dur0), .clr(clr0),
        .full(full0), .playing(playing0), .done(done0), .piezo(piezo0), .piezo_n(piezo_n0)
    );

    note_player #(.FAST_SIM(1), .DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr1), .period(per1), .dur(dur1), .clr(clr1),
        .full(full1), .playing(playing1), .done(done1), .piezo(piezo1), .piezo_n(piezo_n1)
    );

    always #5 clk = ~clk;

    int         npass = 0;
    int         ntotal = 0;
    logic [1:0] expq [2][$];
    int         dtok [2];
    logic       prevpl [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // '1' = piezo high, '0' = piezo low (piezo_n high), 'r' = rest (both low)
    task automatic push_pat(input int k, input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "1":     expq[k].push_back(2'b10);
                "0":     expq[k].push_back(2'b01);
                default: expq[k].push_back(2'b00);
            endcase
        end
    endtask

    task automatic mon(input int k, input logic pl, input logic pz, input logic pzn, input logic dn);
        logic [1:0] e;
        if (prevpl[k] && expq[k].size() != 0)
            chk($sformatf("nogap%0d", k), {31'd0, pl}, 32'd1);
        if (pl) begin
            chk($sformatf("play_expected%0d", k), {31'd0, expq[k].size() != 0}, 32'd1);
            if (expq[k].size() != 0) begin
                e = expq[k].pop_front();
                chk($sformatf("tone%0d", k), {30'd0, pz, pzn}, {30'd0, e});
            end
        end
        if (dn) begin
            chk($sformatf("done_expected%0d", k), {31'd0, dtok[k] > 0}, 32'd1);
            chk($sformatf("done_after_last%0d", k),
                {31'd0, expq[k].size() == 0 && prevpl[k] && !pl}, 32'd1);
            if (dtok[k] > 0) dtok[k]--;
        end
        prevpl[k] = pl;
    endtask

    task automatic drv(input int k, input logic w, input logic [14:0] p, input logic [23:0] d);
        if (k == 0) begin
            wr0 = w; per0 = p; dur0 = d;
        end else begin
            wr1 = w; per1 = p; dur1 = d;
        end
    endtask

    task automatic push(input int k, input logic [14:0] p, input logic [23:0] d);
        drv(k, 1'b1, p, d);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int k, input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (dtok[k] == 0 && expq[k].size() == 0) break;
            @(negedge clk);
        end
        chk(name, {31'd0, dtok[k] == 0 && expq[k].size() == 0}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        prevpl[0] = 1'b0;
        prevpl[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon(0, playing0, piezo0, piezo_n0, done0);
            mon(1, playing1, piezo1, piezo_n1, done1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_full",    {31'd0, full0},    32'd0);
        chk("rst_playing", {31'd0, playing0}, 32'd0);
        chk("rst_done",    {31'd0, done0},    32'd0);
        chk("rst_piezo",   {30'd0, piezo0, piezo_n0}, 32'd0);
        chk("rst_dut1",    {27'd0, full1, playing1, done1, piezo1, piezo_n1}, 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single note, latency to first sounding cycle
        push_pat(0, "110011001100");
        dtok[0]++;
        push(0, 15'd4, 24'd12);
        drv(0, 1'b0, '0, '0);
        @(negedge clk);
        chk("lat_n1_playing", {31'd0, playing0}, 32'd0);
        @(negedge clk);
        chk("lat_n2_playing", {31'd0, playing0}, 32'd1);
        chk("lat_n2_piezo",   {31'd0, piezo0},   32'd1);
        drain(0, 50, "t1_drain");

        // 2: back-to-back notes ending in a rest
        push_pat(0, "11001100");
        push_pat(0, "111000111000");
        push_pat(0, "rrrrr");
        dtok[0]++;
        push(0, 15'd4, 24'd8);
        push(0, 15'd6, 24'd12);
        push(0, 15'd0, 24'd5);
        drv(0, 1'b0, '0, '0);
        drain(0, 100, "t2_drain");

        // 3a: five pushes into an idle block are all accepted
        push_pat(0, "101");
        push_pat(0, "1101");
        push_pat(0, "11");
        push_pat(0, "11100");
        push_pat(0, "11");
        dtok[0]++;
        push(0, 15'd2, 24'd3);
        push(0, 15'd3, 24'd4);
        push(0, 15'd1, 24'd2);
        push(0, 15'd5, 24'd5);
        push(0, 15'd4, 24'd2);
        drv(0, 1'b0, '0, '0);
        drain(0, 100, "t3a_drain");

        // 3b: busy on a long note, 4 pushes fill the FIFO and the 5th is dropped
        for (int i = 0; i < 20; i++) push_pat(0, "10");
        dtok[0]++;
        push(0, 15'd2, 24'd40);
        drv(0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        push_pat(0, "1");
        push_pat(0, "10");
        push_pat(0, "110");
        push_pat(0, "rr");
        push(0, 15'd1, 24'd1);
        push(0, 15'd2, 24'd2);
        push(0, 15'd3, 24'd3);
        push(0, 15'd0, 24'd2);
        drv(0, 1'b1, 15'd1, 24'd7);
        @(negedge clk);
        chk("t3b_full_after4", {31'd0, full0}, 32'd1);
        @(posedge clk); #1;
        drv(0, 1'b0, '0, '0);
        @(negedge clk);
        chk("t3b_full_still", {31'd0, full0}, 32'd1);
        drain(0, 200, "t3b_drain");

        // 4: FAST_SIM duration scaling, dur=0 plays one cycle
        push_pat(1, "101");
        push_pat(1, "r");
        push_pat(1, "10");
        dtok[1]++;
        push(1, 15'd2, 24'd40);
        push(1, 15'd0, 24'd0);
        push(1, 15'd2, 24'd32);
        drv(1, 1'b0, '0, '0);
        drain(1, 50, "t4_drain");

        // 5: clr mid-note with two queued entries; same-cycle push is dropped
        for (int i = 0; i < 50; i++) push_pat(0, "10");
        push_pat(0, "1010");
        push_pat(0, "1010");
        dtok[0]++;
        push(0, 15'd2, 24'd100);
        push(0, 15'd2, 24'd4);
        push(0, 15'd2, 24'd4);
        drv(0, 1'b0, '0, '0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        clr0 = 1'b1;
        drv(0, 1'b1, 15'd1, 24'd3);
        @(posedge clk); #1;
        clr0 = 1'b0;
        drv(0, 1'b0, '0, '0);
        expq[0].delete();
        dtok[0] = 0;
        @(negedge clk);
        chk("t5_playing", {31'd0, playing0}, 32'd0);
        chk("t5_piezo",   {30'd0, piezo0, piezo_n0}, 32'd0);
        chk("t5_full",    {31'd0, full0}, 32'd0);
        chk("t5_done",    {31'd0, done0}, 32'd0);
        repeat (6) @(negedge clk);
        chk("t5_stays_idle", {31'd0, playing0}, 32'd0);
        @(posedge clk); #1;
        push_pat(0, "1100");
        dtok[0]++;
        push(0, 15'd4, 24'd4);
        drv(0, 1'b0, '0, '0);
        drain(0, 50, "t5_drain");

        // 6: asynchronous reset mid-note with entries still queued
        for (int i = 0; i < 25; i++) push_pat(0, "10");
        dtok[0]++;
        push(0, 15'd2, 24'd50);
        push(0, 15'd3, 24'd3);
        push(0, 15'd3, 24'd3);
        drv(0, 1'b0, '0, '0);
        repeat (6) @(negedge clk);
        @(posedge clk); #3;
        chk("t6_playing_before", {31'd0, playing0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_outputs", {27'd0, full0, playing0, done0, piezo0, piezo_n0}, 32'd0);
        expq[0].delete();
        dtok[0] = 0;
        #10 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t6_idle_playing", {31'd0, playing0}, 32'd0);
            chk("t6_idle_full",    {31'd0, full0},    32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
